// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: RX pin front end for the bootloader byte parser.
// A 2-flop synchronizer feeds a 16x-oversampled 8N1 receiver with 3-sample
// majority voting. Received bytes go into a first-word-fall-through FIFO.
// Framing and overrun errors are sticky flags, cleared by err_clr.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit after the data
// bits and a sticky parity_err output.
`default_nettype none

module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic          rx_meta_reg;
    logic          rx_s_reg;
    logic [TW-1:0] tick_cnt_reg;
    logic          tick;
    state_t        state_reg;
    logic [3:0]    sample_cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic          s7_reg;
    logic          s8_reg;
    logic [7:0]    shift_reg;
    logic          vote;
    logic          decide;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          frame_set;
    logic          overrun_set;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic [7:0]    rd_data_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
`ifdef UART_RX_PARITY_EN
    logic          parity_bit_reg;
    logic          parity_ok;
    logic          parity_set;
    logic          parity_err_reg;
`endif

    // Two-flop synchronizer; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= RX;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

    // Oversampling tick divider, re-phased to the falling start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
        end else if ((state_reg == IDLE && !rx_s_reg) || tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + TW'(1);
        end
    end

    // Majority of the samples taken on ticks 7 and 8 plus the live tick-9 sample
    assign vote   = (s7_reg & s8_reg) | (s7_reg & rx_s_reg) | (s8_reg & rx_s_reg);
    assign decide = (state_reg == STOP) && tick && (sample_cnt_reg == 4'd9);

`ifdef UART_RX_PARITY_EN
    assign parity_ok  = ~(^{shift_reg, parity_bit_reg});
    assign parity_set = decide && !parity_ok;
    assign push_req   = decide && vote && parity_ok;
`else
    assign push_req   = decide && vote;
`endif
    assign frame_set   = decide && !vote;
    assign pop         = rd_en && (count_reg != '0);
    assign push_ok     = push_req && (!full || rd_en);
    assign overrun_set = push_req && full && !rd_en;

    // Receive state machine: start validation, data sampling, stop check
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= 4'd0;
            bit_idx_reg    <= 3'd0;
            s7_reg         <= 1'b1;
            s8_reg         <= 1'b1;
            shift_reg      <= 8'd0;
`ifdef UART_RX_PARITY_EN
            parity_bit_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!rx_s_reg) begin
                        state_reg      <= START;
                        sample_cnt_reg <= 4'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sample_cnt_reg == 4'd7) begin
                            sample_cnt_reg <= 4'd0;
                            bit_idx_reg    <= 3'd0;
                            state_reg      <= rx_s_reg ? IDLE : DATA;
                        end else begin
                            sample_cnt_reg <= sample_cnt_reg + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        sample_cnt_reg <= sample_cnt_reg + 4'd1;
                        if (sample_cnt_reg == 4'd7) s7_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd8) s8_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd9) shift_reg <= {vote, shift_reg[7:1]};
                        if (sample_cnt_reg == 4'd15) begin
                            if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state_reg <= PARITY;
`else
                                state_reg <= STOP;
`endif
                            end else begin
                                bit_idx_reg <= bit_idx_reg + 3'd1;
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        sample_cnt_reg <= sample_cnt_reg + 4'd1;
                        if (sample_cnt_reg == 4'd7) s7_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd8) s8_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd9) parity_bit_reg <= vote;
                        if (sample_cnt_reg == 4'd15) state_reg <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        sample_cnt_reg <= sample_cnt_reg + 4'd1;
                        if (sample_cnt_reg == 4'd7) s7_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd8) s8_reg <= rx_s_reg;
                        if (sample_cnt_reg == 4'd9) state_reg <= vote ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must go high before a new start is accepted
                    if (tick && rx_s_reg) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a set event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_set)        frame_err_reg <= 1'b1;
            else if (err_clr)     frame_err_reg <= 1'b0;
            if (overrun_set)      overrun_reg   <= 1'b1;
            else if (err_clr)     overrun_reg   <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, same set-wins rule as the other flags
    always_ff @(posedge clk) begin
        if (rst)             parity_err_reg <= 1'b0;
        else if (parity_set) parity_err_reg <= 1'b1;
        else if (err_clr)    parity_err_reg <= 1'b0;
    end
    assign parity_err = parity_err_reg;
`endif

    // FIFO storage write port; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= shift_reg;
    end

    assign rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Registered head-of-FIFO; bypasses the incoming byte when it becomes the head
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= 8'd0;
        end else if ((push_ok || pop) && count_next != '0) begin
            if (push_ok && wr_ptr_reg == rd_ptr_next) rd_data_reg <= shift_reg;
            else                                      rd_data_reg <= mem[rd_ptr_next];
        end
    end

    assign rd_data   = rd_data_reg;
    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CW'(FIFO_DEPTH));
    assign busy      = (state_reg != IDLE);
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames at the default 432 clk/bit rate; each
// expected value below is worked out by hand from the frame timing.
// Also builds with UART_RX_PARITY_EN defined (parity bit added to frames).
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks_total  = 0;
    int checks_passed = 0;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (RX),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send_bit(input logic v);
        RX = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first and (if enabled) the parity bit
    task automatic send_head(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip);
        send_head(d, par_flip);
        send_bit(1'b1);
        $display("frame 0x%02h sent (parity flip %0d)", d, par_flip);
    endtask

    task automatic pop_byte();
        $display("pop 0x%02h", rd_data);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [7:0] byte_v;
        rst     = 1'b1;
        RX      = 1'b1;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
`ifdef UART_RX_PARITY_EN
        check("rst_parity_err", parity_err, 1'b0);
`endif

        // Single byte: stop decision lands 56 clk into the stop bit
        send_head(8'hA5, 1'b0);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("a5_empty_before_stop_mid", empty, 1'b1);
        repeat (30) @(negedge clk);
        check("a5_empty_after_stop_mid", empty, 1'b0);
        check("a5_rd_data", rd_data, 8'hA5);
        check("a5_busy_idle", busy, 1'b0);
        repeat (BIT_CLKS - 70) @(negedge clk);
        $display("frame 0xa5 sent");
        pop_byte();
        check("a5_empty_after_pop", empty, 1'b1);

        // Glitch: 100 clk low is rejected at the start-bit mid check
        RX = 1'b0;
        repeat (50) @(negedge clk);
        check("glitch_busy_during", busy, 1'b1);
        repeat (50) @(negedge clk);
        RX = 1'b1;
        repeat (130) @(negedge clk);
        check("glitch_busy_after", busy, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        check("glitch_empty", empty, 1'b1);
        check("glitch_frame_err", frame_err, 1'b0);
        $display("glitch sent");

        // Framing error: stop held low for two bit times
        send_head(8'h3C, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        RX = 1'b1;
        $display("frame 0x3c sent with low stop");
        check("fe_frame_err", frame_err, 1'b1);
        check("fe_busy_wait_high", busy, 1'b1);
        send_bit(1'b1);
        check("fe_busy_released", busy, 1'b0);
        check("fe_empty", empty, 1'b1);
        send_frame(8'h55, 1'b0);
        check("fe_next_empty", empty, 1'b0);
        check("fe_next_rd_data", rd_data, 8'h55);
        check("fe_frame_err_held", frame_err, 1'b1);
        pop_byte();
        pulse_err_clr();
        check("fe_frame_err_cleared", frame_err, 1'b0);

        // Fill and overrun: 8 bytes fill, the 9th is dropped
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0);
        check("fill_full", full, 1'b1);
        check("fill_overrun", overrun, 1'b0);
        check("fill_head", rd_data, 8'h01);
        send_frame(8'h09, 1'b0);
        check("ovr_overrun", overrun, 1'b1);
        check("ovr_full", full, 1'b1);
        pulse_err_clr();
        check("ovr_cleared", overrun, 1'b0);

        // Collision: pop on the push cycle of 0x77 while full
        send_head(8'h77, 1'b0);
        RX = 1'b1;
        repeat (56) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("col_head_after_pop", rd_data, 8'h02);
        check("col_full", full, 1'b1);
        check("col_overrun", overrun, 1'b0);
        repeat (BIT_CLKS - 57) @(negedge clk);
        $display("frame 0x77 sent with pop on push cycle");
        for (int i = 2; i <= 8; i++) begin
            check("col_read", rd_data, 8'(i));
            pop_byte();
        end
        check("col_last_read", rd_data, 8'h77);
        check("col_last_not_empty", empty, 1'b0);

        // Reset during bit 4 with 0x77 still queued
        byte_v = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(byte_v[i]);
        RX = byte_v[4];
        repeat (200) @(negedge clk);
        rst = 1'b1;
        RX  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset during bit 4 of 0xc3");
        check("mid_rst_rd_data", rd_data, 8'h00);
        check("mid_rst_empty", empty, 1'b1);
        check("mid_rst_full", full, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_err", frame_err, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'hC3, 1'b0);
        check("c3_empty", empty, 1'b0);
        check("c3_rd_data", rd_data, 8'hC3);
        pop_byte();
        check("c3_empty_after_pop", empty, 1'b1);

`ifdef UART_RX_PARITY_EN
        // 0xC3 has even weight, so a parity bit of 1 is a mismatch
        send_frame(8'hC3, 1'b1);
        check("par_parity_err", parity_err, 1'b1);
        check("par_empty", empty, 1'b1);
        check("par_frame_err", frame_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
UART receive front end that feeds the bootloader's byte parser from the board RX pin. It provides:
- a 2-flop synchronizer;
- 16x-oversampled 8N1 reception with majority voting;
- a small first-word-fall-through byte FIFO.

It decouples serial arrival from the bootloader's word assembly and reports framing and overrun errors as sticky flags.

Parameters:
- CLK_FREQ, 50000000: clk frequency in Hz.
- BAUD, 115200: line rate in bits per second.
- FIFO_DEPTH, 8: byte FIFO entries; must be a power of 2, at least 2.

Ports:
- clk, input, 1: global clock; all logic is on the rising edge.
- rst, input, 1: synchronous active-high reset.
- RX, input, 1: asynchronous serial line; idles high.
- rd_en, input, 1: pop the head byte; ignored when empty=1.
- rd_data, output, 8: FIFO head byte; valid while empty=0.
- empty, output, 1: FIFO holds 0 bytes.
- full, output, 1: FIFO holds FIFO_DEPTH bytes.
- busy, output, 1: receiver is outside IDLE.
- frame_err, output, 1: sticky; stop bit sampled low.
- overrun, output, 1: sticky; a byte was dropped because the FIFO was full.
- err_clr, input, 1: clears frame_err and overrun.

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high; the clock and reset ports are named as the codebase does.
- Reset values:
  - rd_data=0, empty=1, full=0, busy=0, frame_err=0, overrun=0.
  - Synchronizer flops reset to 1.
  - FIFO pointers and count reset to 0.
  - FSM resets to IDLE.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD*16), truncated; the default is 27.
  - The counter runs 0..TICK_DIV-1 and pulses tick for one cycle at wrap.
  - Bit period = 16 ticks (432 clk at the defaults).
  - The counter restarts at 0 on the IDLE->START transition so sampling phase aligns to the start edge.
- Synchronized input rx_s is RX delayed by 2 flops.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: rx_s==0 -> START, sample counter=0.
  - START: on tick 7 (8th tick), if rx_s==1, treat as a glitch -> IDLE with no error. Otherwise reset the sample counter -> DATA, bit index=0.
  - DATA:
    - Sample rx_s on ticks 7, 8 and 9 of each bit; the bit value is the majority of the 3 samples.
    - Bits shift in LSB first.
    - On tick 15 of bit 7 -> STOP.
  - STOP: majority vote on ticks 7/8/9; decision on tick 9.
    - If 1: push the byte, -> IDLE.
    - If 0: set frame_err, discard the byte, -> WAIT_HIGH.
  - WAIT_HIGH: remain until rx_s==1 for one tick, then -> IDLE. This prevents a break condition from retriggering.
- Push:
  - The byte is visible at rd_data, with empty=0, on the cycle after the STOP decision tick.
  - If the FIFO is full at push and rd_en is not asserted that cycle: drop the byte and set overrun.
  - Push and pop in the same cycle while full: both occur, no overrun, count unchanged.
- Pop: rd_en && !empty advances the read pointer. The next byte (or empty) is presented on the following cycle.
- Simultaneous push and pop while empty: no pop occurs; the push lands.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.
- Flag priority:
  - A set event in the same cycle as err_clr leaves the flag set (set wins).
  - Each flag is otherwise held until err_clr or rst.
- busy = (state != IDLE).
- Reset mid-frame: rst aborts reception; the partial byte is lost. FIFO contents are cleared, not preserved.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, sampled with the same 7/8/9 majority vote.
  - Even parity is checked over data+parity. On mismatch, the byte is discarded and output parity_err (1 bit, sticky, cleared by err_clr, reset 0) is set.
  - Stop-bit handling is unchanged. A frame with both parity and stop errors sets both flags.
- Not defined: frames are 8N1 only; no parity_err port exists.

Test Plan:
- Defaults, single byte: drive 0xA5 at 432 clk/bit, idle high. empty deasserts within 1 cycle after the stop-bit mid sample; rd_data=0xA5; rd_en pulse -> empty=1.
- Glitch rejection: RX low for 100 clk, then high. No push; busy returns to 0 by 8 ticks after the edge (within 216 clk); frame_err=0.
- Framing error: send 0x3C with stop bit held low, then release RX after 2 bit times. frame_err=1; FIFO stays empty; the next 0x55 frame is received correctly; err_clr -> frame_err=0.
- Overrun / fill: send 9 bytes 0x01..0x09 without reading. full=1 after 8 bytes; overrun=1 after the 9th; reads return 0x01..0x08, then empty=1.
- Push/pop collision: with the FIFO full, assert rd_en on the push cycle of a 9th byte 0x77. overrun stays 0; count remains 8; the last read is 0x77.
- Reset mid-frame: assert rst for 1 cycle during bit 4 of a frame. All outputs return to reset values; the next full frame 0xC3 is received correctly. With UART_RX_PARITY_EN defined, 0xC3 with parity bit 1 sets parity_err=1 and no push occurs.
